// File: rtl/disp_scan_ctrl.sv
// Scan-index generator and frame-synchronous shadow registers for a 4-digit
// seven-segment display, with per-digit blink applied to the blanking bits.
module disp_scan_ctrl #(
  parameter int DIV_W   = 17,
  parameter int BLINK_W = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] hexs_in,
  input  logic [3:0]  point_in,
  input  logic [3:0]  les_in,
  input  logic [3:0]  blink_en_in,
  output logic [1:0]  Scan,
  output logic [15:0] Hexs,
  output logic [3:0]  point,
  output logic [3:0]  LES,
  output logic        busy,
  output logic        frame_tick
);

  localparam logic [DIV_W-1:0]   DIV_ONE   = 1;
  localparam logic [BLINK_W-1:0] BLINK_ONE = 1;

  logic [DIV_W-1:0]   div_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [3:0]         les_sh;
  logic [3:0]         blink_sh;
  logic [15:0]        pend_hexs;
  logic [3:0]         pend_point;
  logic [3:0]         pend_les;
  logic [3:0]         pend_blink;

  logic               dwell_end;
  logic               fb;
  logic               phase;
  logic [3:0]         nxt_les;
  logic [3:0]         nxt_blink;

  assign dwell_end = &div_cnt;
  assign fb        = dwell_end && (Scan == 2'd3);
  assign phase     = blink_cnt[BLINK_W-1];

  // LES is built from the post-edge shadow values so a new blanking pattern
  // appears on the same edge as the new digits.
  always_comb begin
    nxt_les   = les_sh;
    nxt_blink = blink_sh;
    if (fb && load) begin
      nxt_les   = les_in;
      nxt_blink = blink_en_in;
    end else if (fb && busy) begin
      nxt_les   = pend_les;
      nxt_blink = pend_blink;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      blink_cnt  <= '0;
      Scan       <= 2'd0;
      Hexs       <= 16'h0000;
      point      <= 4'h0;
      les_sh     <= 4'hF;
      blink_sh   <= 4'h0;
      LES        <= 4'hF;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      pend_hexs  <= 16'h0000;
      pend_point <= 4'h0;
      pend_les   <= 4'h0;
      pend_blink <= 4'h0;
    end else begin
      div_cnt    <= div_cnt + DIV_ONE;
      blink_cnt  <= blink_cnt + BLINK_ONE;
      frame_tick <= fb;
      les_sh     <= nxt_les;
      blink_sh   <= nxt_blink;
      LES        <= nxt_les | (nxt_blink & {4{phase}});
      if (dwell_end)
        Scan <= Scan + 2'd1;

      if (fb) begin
        busy <= 1'b0;
        if (load) begin
          Hexs  <= hexs_in;
          point <= point_in;
        end else if (busy) begin
          Hexs  <= pend_hexs;
          point <= pend_point;
        end
      end else if (load) begin
        pend_hexs  <= hexs_in;
        pend_point <= point_in;
        pend_les   <= les_in;
        pend_blink <= blink_en_in;
        busy       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl with DIV_W=2, BLINK_W=4: 16-cycle frames; a
// scoreboard checks the displayed data at every frame_tick.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] hexs_in = 16'h0;
  logic [3:0]  point_in = 4'h0;
  logic [3:0]  les_in = 4'h0;
  logic [3:0]  blink_en_in = 4'h0;
  logic [1:0]  Scan;
  logic [15:0] Hexs;
  logic [3:0]  point;
  logic [3:0]  LES;
  logic        busy;
  logic        frame_tick;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.DIV_W(2), .BLINK_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .hexs_in(hexs_in),
    .point_in(point_in), .les_in(les_in), .blink_en_in(blink_en_in),
    .Scan(Scan), .Hexs(Hexs), .point(point), .LES(LES), .busy(busy),
    .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [15:0] h;
    logic [3:0]  p;
    logic [3:0]  l;
    logic        b;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Position within the 16-cycle frame, kept independently of the DUT.
  logic [3:0] pos;
  logic       seen_wrap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos       <= 4'd0;
      seen_wrap <= 1'b0;
    end else begin
      pos <= pos + 4'd1;
      if (pos == 4'd15)
        seen_wrap <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("scan", {30'd0, Scan}, {30'd0, pos[3:2]});
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, (pos == 4'd0) && seen_wrap});
      if (frame_tick && q.size() > 0) begin
        e = q.pop_front();
        chk("frame_hexs", {16'd0, Hexs}, {16'd0, e.h});
        chk("frame_point", {28'd0, point}, {28'd0, e.p});
        chk("frame_les", {28'd0, LES}, {28'd0, e.l});
        chk("frame_busy", {31'd0, busy}, {31'd0, e.b});
      end
    end
  end

  task automatic wait_pos(input logic [3:0] p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pos != p && n < 64);
    if (pos != p) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_pos: got pos %0d expected %0d", pos, p);
    end
  endtask

  task automatic put(input logic [15:0] h, input logic [3:0] p,
                     input logic [3:0] l, input logic [3:0] b);
    load        = 1'b1;
    hexs_in     = h;
    point_in    = p;
    les_in      = l;
    blink_en_in = b;
  endtask

  initial begin
    logic [3:0] pm;

    // reset release, idle frames
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_hexs", {16'd0, Hexs}, 32'h0);
    chk("rst_les", {28'd0, LES}, 32'hF);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_point", {28'd0, point}, 32'h0);
    q.push_back('{h: 16'h0000, p: 4'h0, l: 4'hF, b: 1'b0});
    q.push_back('{h: 16'h0000, p: 4'h0, l: 4'hF, b: 1'b0});
    wait_pos(4'd0);
    wait_pos(4'd0);

    // mid-frame load waits for the frame boundary
    wait_pos(4'd5);
    put(16'h1234, 4'b0010, 4'b0000, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    chk("t2_busy", {31'd0, busy}, 32'h1);
    chk("t2_hexs_held", {16'd0, Hexs}, 32'h0);
    q.push_back('{h: 16'h1234, p: 4'b0010, l: 4'b0000, b: 1'b0});
    wait_pos(4'd15);
    chk("t2_hexs_last", {16'd0, Hexs}, 32'h0);
    chk("t2_busy_last", {31'd0, busy}, 32'h1);
    wait_pos(4'd0);

    // two loads in one frame: last one wins
    wait_pos(4'd2);
    put(16'hAAAA, 4'b1111, 4'b0000, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    chk("t3_busy", {31'd0, busy}, 32'h1);
    chk("t3_hexs_held", {16'd0, Hexs}, 32'h1234);
    wait_pos(4'd9);
    put(16'h5555, 4'b0101, 4'b1010, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    chk("t3_hexs_held2", {16'd0, Hexs}, 32'h1234);
    q.push_back('{h: 16'h5555, p: 4'b0101, l: 4'b1010, b: 1'b0});
    wait_pos(4'd0);

    // load coincident with the frame boundary bypasses pending
    wait_pos(4'd15);
    chk("t4_busy_before", {31'd0, busy}, 32'h0);
    put(16'hBEEF, 4'b1000, 4'b0001, 4'b0000);
    q.push_back('{h: 16'hBEEF, p: 4'b1000, l: 4'b0001, b: 1'b0});
    @(negedge clk);
    load = 1'b0;
    chk("t4_scan0", {30'd0, Scan}, 32'h0);

    // blink on digit 0; blink counter runs in step with the frame position
    wait_pos(4'd15);
    put(16'h0F0F, 4'b0000, 4'b0000, 4'b0001);
    q.push_back('{h: 16'h0F0F, p: 4'b0000, l: 4'b0001, b: 1'b0});
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pm = pos + 4'd15;
      chk("blink_les", {28'd0, LES}, {28'd0, 3'b000, pm[3]});
      @(negedge clk);
    end

    // reset while a load is pending
    wait_pos(4'd4);
    put(16'hDEAD, 4'b1111, 4'b0000, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_scan", {30'd0, Scan}, 32'h0);
    chk("t6_rst_hexs", {16'd0, Hexs}, 32'h0);
    chk("t6_rst_point", {28'd0, point}, 32'h0);
    chk("t6_rst_les", {28'd0, LES}, 32'hF);
    chk("t6_rst_busy", {31'd0, busy}, 32'h0);
    chk("t6_rst_tick", {31'd0, frame_tick}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back('{h: 16'h0000, p: 4'h0, l: 4'hF, b: 1'b0});
    q.push_back('{h: 16'h0000, p: 4'h0, l: 4'hF, b: 1'b0});
    wait_pos(4'd8);
    chk("t6_busy_after", {31'd0, busy}, 32'h0);
    wait_pos(4'd0);
    wait_pos(4'd0);
    @(negedge clk);

    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
